// File: rtl/window_gen_3x3.sv
// 3x3 sliding-window generator for raster pixel streams: two line buffers feed
// a 3x3 window register; windows are emitted only for valid (unpadded) positions.
module window_gen_3x3 #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              pix_valid,
    input  logic signed [7:0] pix_in,
    output logic              pix_ready,
    output logic signed [7:0] win_0,
    output logic signed [7:0] win_1,
    output logic signed [7:0] win_2,
    output logic signed [7:0] win_3,
    output logic signed [7:0] win_4,
    output logic signed [7:0] win_5,
    output logic signed [7:0] win_6,
    output logic signed [7:0] win_7,
    output logic signed [7:0] win_8,
    output logic              win_valid,
    input  logic              win_ready,
    output logic              frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

    state_t            state, state_nx;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic signed [7:0] lb0 [IMG_W];
    logic signed [7:0] lb1 [IMG_W];
    logic signed [7:0] win [9];
    logic              accept, col_last, row_last, produce;

    assign pix_ready = !win_valid || win_ready;
    // clear takes priority over a simultaneous handshake: the pixel is discarded
    assign accept    = pix_valid && pix_ready && !clear;
    assign col_last  = (col == CW'(IMG_W - 1));
    assign row_last  = (row == RW'(IMG_H - 1));
    assign produce   = accept && (state == STREAM) && (col >= CW'(2));

    always_comb begin
        state_nx = state;
        if (clear) begin
            state_nx = IDLE;
        end else if (accept) begin
            case (state)
                IDLE:    state_nx = FILL;
                FILL:    if (row == RW'(1) && col_last) state_nx = STREAM;
                STREAM:  if (row_last && col_last) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            row        <= '0;
            col        <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            win        <= '{default: '0};
        end else begin
            state      <= state_nx;
            frame_done <= accept && row_last && col_last;
            if (clear) begin
                row       <= '0;
                col       <= '0;
                win_valid <= 1'b0;
            end else begin
                if (produce)
                    win_valid <= 1'b1;
                else if (win_ready)
                    win_valid <= 1'b0;
                if (accept) begin
                    if (col_last) begin
                        col <= '0;
                        row <= row_last ? '0 : row + RW'(1);
                    end else begin
                        col <= col + CW'(1);
                    end
                    win[0] <= win[1];
                    win[1] <= win[2];
                    win[2] <= lb1[col];
                    win[3] <= win[4];
                    win[4] <= win[5];
                    win[5] <= lb0[col];
                    win[6] <= win[7];
                    win[7] <= win[8];
                    win[8] <= pix_in;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col] <= lb0[col];
            lb0[col] <= pix_in;
        end
    end

    assign win_0 = win[0];
    assign win_1 = win[1];
    assign win_2 = win[2];
    assign win_3 = win[3];
    assign win_4 = win[4];
    assign win_5 = win[5];
    assign win_6 = win[6];
    assign win_7 = win[7];
    assign win_8 = win[8];

endmodule

// File: tb/tb_window_gen_3x3.sv
// Self-checking bench for window_gen_3x3 on a 4x4 image against an image-array model.
module tb_window_gen_3x3;

    localparam int W = 4;
    localparam int H = 4;
    localparam logic [71:0] FIRST = {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11};
    localparam logic [71:0] LAST  = {8'd6, 8'd7, 8'd8, 8'd10, 8'd11, 8'd12, 8'd14, 8'd15, 8'd16};

    logic clk = 1'b0;
    logic rst = 1'b0, clear = 1'b0, pix_valid = 1'b0, win_ready = 1'b0;
    logic signed [7:0] pix_in = '0;
    logic pix_ready, win_valid, frame_done;
    logic signed [7:0] win_0, win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8;

    always #5 clk = ~clk;

    window_gen_3x3 #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst), .clear(clear), .pix_valid(pix_valid), .pix_in(pix_in),
        .pix_ready(pix_ready),
        .win_0(win_0), .win_1(win_1), .win_2(win_2), .win_3(win_3), .win_4(win_4),
        .win_5(win_5), .win_6(win_6), .win_7(win_7), .win_8(win_8),
        .win_valid(win_valid), .win_ready(win_ready), .frame_done(frame_done)
    );

    int vecs = 0, errs = 0;

    // reference model: the image itself plus a pending-window flag
    logic signed [7:0] img [H][W];
    int m_r = 0, m_c = 0, m_done_cnt = 0, obs_done_cnt = 0;
    bit m_valid = 0, m_acc = 0, m_done = 0, m_ready = 0, pre_ready = 0;
    logic [71:0] m_win = '0;
    logic [71:0] exq[$];
    logic [71:0] obs[$];

    function automatic logic [71:0] win_at(input int r, input int c);
        logic [71:0] w;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                w[71 - 8*(dr*3 + dc) -: 8] = img[r-2+dr][c-2+dc];
        return w;
    endfunction

    function automatic logic [71:0] dut_win();
        return {win_0, win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8};
    endfunction

    task automatic drive(input bit pv, input logic signed [7:0] px, input bit wr, input bit clr);
        bit produced;
        @(negedge clk);
        pix_valid = pv; pix_in = px; win_ready = wr; clear = clr;
        #1;
        pre_ready = pix_ready;
        if (win_valid && win_ready) obs.push_back(dut_win());
        m_ready  = !m_valid || wr;
        m_acc    = pv && m_ready && !clr;
        produced = 0;
        m_done   = 0;
        if (clr) begin
            m_r = 0; m_c = 0; m_valid = 0;
        end else begin
            if (m_acc) begin
                img[m_r][m_c] = px;
                if (m_r >= 2 && m_c >= 2) begin
                    produced = 1;
                    m_win = win_at(m_r, m_c);
                    exq.push_back(m_win);
                end
                if (m_r == H-1 && m_c == W-1) m_done = 1;
                if (m_c == W-1) begin
                    m_c = 0;
                    m_r = (m_r == H-1) ? 0 : m_r + 1;
                end else begin
                    m_c++;
                end
            end
            if (produced) m_valid = 1;
            else if (wr)  m_valid = 0;
        end
        if (m_done) m_done_cnt++;
        @(posedge clk);
        #1;
        if (frame_done) obs_done_cnt++;
    endtask

    task automatic start();
        obs.delete(); exq.delete();
        m_done_cnt = 0; obs_done_cnt = 0;
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        pix_valid = 0; clear = 0; win_ready = 0;
        rst = 1;
        #2;
        vecs++; if (win_valid !== 1'b0) begin errs++; $display("FAIL rst_valid: got %b want 0", win_valid); end
        vecs++; if (frame_done !== 1'b0) begin errs++; $display("FAIL rst_done: got %b want 0", frame_done); end
        vecs++; if (pix_ready !== 1'b1) begin errs++; $display("FAIL rst_ready: got %b want 1", pix_ready); end
        vecs++; if (dut_win() !== 72'h0) begin errs++; $display("FAIL rst_window: got %h want 0", dut_win()); end
        @(negedge clk);
        rst = 0;
        m_r = 0; m_c = 0; m_valid = 0;
    endtask

    task automatic test_reset();
        #1 rst = 1;
        #2;
        vecs++; if (win_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b want 0", win_valid); end
        vecs++; if (frame_done !== 1'b0) begin errs++; $display("FAIL reset_done: got %b want 0", frame_done); end
        vecs++; if (pix_ready !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b want 1", pix_ready); end
        vecs++; if (dut_win() !== 72'h0) begin errs++; $display("FAIL reset_window: got %h want 0", dut_win()); end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_frame();
        start();
        for (int p = 1; p <= 16; p++) drive(1, 8'(p), 1, 0);
        vecs++; if (frame_done !== 1'b1 || win_valid !== 1'b1) begin errs++; $display("FAIL frame_last_done: got done=%b valid=%b want 1 1", frame_done, win_valid); end
        vecs++; if (dut_win() !== LAST) begin errs++; $display("FAIL frame_last_win: got %h want %h", dut_win(), LAST); end
        drive(0, 0, 1, 0);
        vecs++; if (frame_done !== 1'b0) begin errs++; $display("FAIL frame_done_len: got %b want 0", frame_done); end
        vecs++; if (obs.size() != 4) begin errs++; $display("FAIL frame_count: got %0d want 4", obs.size()); end
        vecs++; if (obs_done_cnt != 1) begin errs++; $display("FAIL frame_done_cnt: got %0d want 1", obs_done_cnt); end
        if (obs.size() >= 4) begin
            vecs++; if (obs[0] !== FIRST) begin errs++; $display("FAIL frame_first: got %h want %h", obs[0], FIRST); end
            for (int i = 0; i < 4; i++) begin
                vecs++; if (obs[i] !== exq[i]) begin errs++; $display("FAIL frame_win%0d: got %h want %h", i, obs[i], exq[i]); end
            end
        end
    endtask

    task automatic test_stall();
        int p = 1, hold = 0, guard = 0;
        bit seen = 0;
        start();
        while (p <= 16 && guard < 100) begin
            guard++;
            drive(1, 8'(p), hold == 0, 0);
            if (m_acc) p++;
            if (hold > 0) begin
                vecs++; if (pre_ready !== 1'b0) begin errs++; $display("FAIL stall_ready: got %b want 0", pre_ready); end
                vecs++; if (dut_win() !== FIRST) begin errs++; $display("FAIL stall_hold: got %h want %h", dut_win(), FIRST); end
                hold--;
            end else if (!seen && win_valid) begin
                seen = 1;
                hold = 3;
            end
        end
        vecs++; if (guard >= 100) begin errs++; $display("FAIL stall_timeout: got %0d cycles want <100", guard); end
        drive(0, 0, 1, 0);
        vecs++; if (obs.size() != 4) begin errs++; $display("FAIL stall_count: got %0d want 4", obs.size()); end
        if (obs.size() >= 4) begin
            vecs++; if (obs[0] !== FIRST) begin errs++; $display("FAIL stall_first: got %h want %h", obs[0], FIRST); end
            vecs++; if (obs[3] !== LAST) begin errs++; $display("FAIL stall_last: got %h want %h", obs[3], LAST); end
        end
    endtask

    task automatic test_back_to_back();
        start();
        for (int f = 0; f < 2; f++)
            for (int p = 1; p <= 16; p++) drive(1, 8'(p), 1, 0);
        drive(0, 0, 1, 0);
        vecs++; if (obs.size() != 8) begin errs++; $display("FAIL b2b_count: got %0d want 8", obs.size()); end
        vecs++; if (obs_done_cnt != 2) begin errs++; $display("FAIL b2b_done_cnt: got %0d want 2", obs_done_cnt); end
        if (obs.size() >= 8)
            for (int i = 0; i < 4; i++) begin
                vecs++; if (obs[i+4] !== obs[i] || obs[i] !== exq[i]) begin errs++; $display("FAIL b2b_win%0d: got %h/%h want %h", i, obs[i], obs[i+4], exq[i]); end
            end
    endtask

    task automatic test_signed();
        logic signed [7:0] v;
        start();
        for (int p = 0; p < 16; p++) begin
            v = (p == 0) ? -8'sd128 : (p == 1) ? 8'sd127 : (p == 2) ? -8'sd1 : 8'(p + 1);
            drive(1, v, 1, 0);
        end
        drive(0, 0, 1, 0);
        vecs++; if (obs.size() != 4) begin errs++; $display("FAIL signed_count: got %0d want 4", obs.size()); end
        if (obs.size() >= 1) begin
            vecs++; if (obs[0][71:48] !== 24'h807FFF) begin errs++; $display("FAIL signed_top: got %h want 807fff", obs[0][71:48]); end
            vecs++; if (obs[0] !== exq[0]) begin errs++; $display("FAIL signed_win: got %h want %h", obs[0], exq[0]); end
        end
    endtask

    task automatic test_rst_mid();
        start();
        for (int p = 1; p <= 9; p++) drive(1, 8'(p + 100), 1, 0);
        pulse_rst();
        start();
        for (int p = 1; p <= 16; p++) drive(1, 8'(p), 1, 0);
        drive(0, 0, 1, 0);
        vecs++; if (obs.size() != 4) begin errs++; $display("FAIL rstmid_count: got %0d want 4", obs.size()); end
        if (obs.size() >= 4) begin
            vecs++; if (obs[0] !== FIRST) begin errs++; $display("FAIL rstmid_first: got %h want %h", obs[0], FIRST); end
            vecs++; if (obs[3] !== LAST) begin errs++; $display("FAIL rstmid_last: got %h want %h", obs[3], LAST); end
        end
    endtask

    task automatic test_clear();
        start();
        for (int p = 1; p <= 5; p++) drive(1, 8'(p + 50), 1, 0);
        drive(1, 8'd56, 1, 1);
        vecs++; if (win_valid !== 1'b0) begin errs++; $display("FAIL clear_valid: got %b want 0", win_valid); end
        for (int p = 1; p <= 16; p++) drive(1, 8'(p), 1, 0);
        drive(0, 0, 1, 0);
        vecs++; if (obs.size() != 4) begin errs++; $display("FAIL clear_count: got %0d want 4", obs.size()); end
        vecs++; if (obs_done_cnt != 1) begin errs++; $display("FAIL clear_done_cnt: got %0d want 1", obs_done_cnt); end
        if (obs.size() >= 4) begin
            vecs++; if (obs[0] !== FIRST) begin errs++; $display("FAIL clear_first: got %h want %h", obs[0], FIRST); end
            vecs++; if (obs[3] !== LAST) begin errs++; $display("FAIL clear_last: got %h want %h", obs[3], LAST); end
        end
    endtask

    task automatic test_random();
        int guard = 0;
        start();
        while (m_done_cnt < 3 && guard < 2000) begin
            guard++;
            drive(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0, 0);
            vecs++; if (pre_ready !== m_ready) begin errs++; $display("FAIL rand_ready: got %b want %b", pre_ready, m_ready); end
            vecs++; if (win_valid !== m_valid) begin errs++; $display("FAIL rand_valid: got %b want %b", win_valid, m_valid); end
            vecs++; if (frame_done !== m_done) begin errs++; $display("FAIL rand_done: got %b want %b", frame_done, m_done); end
            if (m_valid) begin
                vecs++; if (dut_win() !== m_win) begin errs++; $display("FAIL rand_win: got %h want %h", dut_win(), m_win); end
            end
        end
        vecs++; if (guard >= 2000) begin errs++; $display("FAIL rand_timeout: got %0d frames want 3", m_done_cnt); end
        drive(0, 0, 1, 0);
        vecs++; if (obs.size() != exq.size()) begin errs++; $display("FAIL rand_count: got %0d want %0d", obs.size(), exq.size()); end
        for (int i = 0; i < obs.size() && i < exq.size(); i++) begin
            vecs++; if (obs[i] !== exq[i]) begin errs++; $display("FAIL rand_win%0d: got %h want %h", i, obs[i], exq[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_stall();
        test_back_to_back();
        test_signed();
        test_rst_mid();
        test_clear();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
